// File: rtl/ternary_max_reducer.sv
// ternary_max_reducer
//   Reduces a packet of trits to its ternary maximum and minimum, the number
//   of trits accepted and an error flag. Trit codes: 00 = -, 01 = 0, 10 = +,
//   11 = invalid. The result is registered on the accept of the packet's
//   last trit and held until downstream takes it.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   ACC   | accumulating trits of the current packet, in_ready high
//   OUT   | result presented on out_*, waiting for out_ready
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   upstream offers in_trit / in_last this cycle
//   in_trit    2-bit trit code
//   in_last    offered trit closes the packet
//   in_ready   block accepts a trit this cycle
//   out_valid  packet result presented
//   out_ready  downstream takes the presented result
//   out_max    maximum of the packet's valid trits (01 if there were none)
//   out_min    minimum of the packet's valid trits (01 if there were none)
//   out_count  trits accepted, invalid ones included, saturating
//   out_err    packet held an 11 code or no valid trit at all
module ternary_max_reducer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       in_trit,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_max,
    output logic [1:0]       out_min,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err
);

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    localparam logic [1:0]       T_NEG   = 2'b00;
    localparam logic [1:0]       T_ZERO  = 2'b01;
    localparam logic [1:0]       T_POS   = 2'b10;
    localparam logic [1:0]       T_INV   = 2'b11;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nxt;

    logic [1:0]       acc_max;
    logic [1:0]       acc_min;
    logic [CNT_W-1:0] acc_cnt;
    logic             acc_err;
    logic             acc_seen;

    logic             accept;
    logic             handshake;
    logic             trit_ok;
    logic [1:0]       max_upd;
    logic [1:0]       min_upd;
    logic [CNT_W-1:0] cnt_upd;
    logic             err_upd;
    logic             seen_upd;

    // rst gates in_ready so nothing is offered as accepted while reset is held
    assign in_ready  = (state == ACC) && !rst;
    assign out_valid = (state == OUT);
    assign accept    = in_ready && in_valid;
    assign handshake = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACC: if (accept && in_last) state_nxt = OUT;
            OUT: if (handshake)         state_nxt = ACC;
            default:                    state_nxt = ACC;
        endcase
    end

    // Accumulator values including the trit offered this cycle; used both to
    // advance the accumulators and to load the result on the last trit.
    always_comb begin
        trit_ok  = (in_trit != T_INV);
        max_upd  = (trit_ok && (in_trit > acc_max)) ? in_trit : acc_max;
        min_upd  = (trit_ok && (in_trit < acc_min)) ? in_trit : acc_min;
        cnt_upd  = (acc_cnt == {CNT_W{1'b1}}) ? acc_cnt : acc_cnt + CNT_ONE;
        err_upd  = acc_err || !trit_ok;
        seen_upd = acc_seen || trit_ok;
    end

    // Start values 00 / 10 are the identities for max / min, so the first
    // valid trit always lands in both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_max  <= T_NEG;
            acc_min  <= T_POS;
            acc_cnt  <= '0;
            acc_err  <= 1'b0;
            acc_seen <= 1'b0;
        end else if (handshake) begin
            acc_max  <= T_NEG;
            acc_min  <= T_POS;
            acc_cnt  <= '0;
            acc_err  <= 1'b0;
            acc_seen <= 1'b0;
        end else if (accept) begin
            acc_max  <= max_upd;
            acc_min  <= min_upd;
            acc_cnt  <= cnt_upd;
            acc_err  <= err_upd;
            acc_seen <= seen_upd;
        end
    end

    // Result registers only load on the last accept, so they keep the
    // previous packet's values after the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_max   <= 2'b00;
            out_min   <= 2'b00;
            out_count <= '0;
            out_err   <= 1'b0;
        end else if (accept && in_last) begin
            out_max   <= seen_upd ? max_upd : T_ZERO;
            out_min   <= seen_upd ? min_upd : T_ZERO;
            out_count <= cnt_upd;
            out_err   <= err_upd || !seen_upd;
        end
    end

endmodule

// File: tb/tb_ternary_max_reducer.sv
module tb_ternary_max_reducer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] in_trit;
    logic       in_last;
    logic       out_ready;

    logic       in_ready,  in_ready2;
    logic       out_valid, out_valid2;
    logic [1:0] out_max,   out_max2;
    logic [1:0] out_min,   out_min2;
    logic [7:0] out_count;
    logic [1:0] out_count2;
    logic       out_err,   out_err2;

    always #5 clk = ~clk;

    ternary_max_reducer #(.CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_trit(in_trit),
        .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_max(out_max), .out_min(out_min),
        .out_count(out_count), .out_err(out_err)
    );

    // Narrow counter copy fed with identical stimulus, for saturation checks.
    ternary_max_reducer #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_trit(in_trit),
        .in_last(in_last), .in_ready(in_ready2), .out_valid(out_valid2),
        .out_ready(out_ready), .out_max(out_max2), .out_min(out_min2),
        .out_count(out_count2), .out_err(out_err2)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [1:0] part[$];
    bit         m_out = 1'b0;
    int         e_max = 0, e_min = 0, e_cnt8 = 0, e_cnt2 = 0, e_err = 0;
    int         n_hs = 0;
    int         n_bubble = 0;
    bit         b2b = 1'b0;

    // Values -1/0/+1 are the code minus one; the result is a plain max/min.
    function automatic void model_result();
        int  mx = -2;
        int  mn = 2;
        bit  inv = 1'b0;
        int  n = part.size();
        foreach (part[k]) begin
            if (part[k] == 2'b11) inv = 1'b1;
            else begin
                int v = int'(part[k]) - 1;
                if (v > mx) mx = v;
                if (v < mn) mn = v;
            end
        end
        if (mx == -2) begin
            e_max = 1; e_min = 1; e_err = 1;
        end else begin
            e_max = mx + 1; e_min = mn + 1; e_err = int'(inv);
        end
        e_cnt8 = (n > 255) ? 255 : n;
        e_cnt2 = (n > 3) ? 3 : n;
    endfunction

    // Inputs change only just after posedge, so the negedge view predicts
    // exactly what the following posedge does.
    always @(negedge clk) begin
        if (rst) begin
            part.delete();
            m_out = 1'b0;
            e_max = 0; e_min = 0; e_cnt8 = 0; e_cnt2 = 0; e_err = 0;
        end
        chk("in_ready",   int'(in_ready),   int'(!m_out && !rst));
        chk("out_valid",  int'(out_valid),  int'(m_out));
        chk("out_max",    int'(out_max),    e_max);
        chk("out_min",    int'(out_min),    e_min);
        chk("out_count",  int'(out_count),  e_cnt8);
        chk("out_err",    int'(out_err),    e_err);
        chk("sat_ready",  int'(in_ready2),  int'(!m_out && !rst));
        chk("sat_valid",  int'(out_valid2), int'(m_out));
        chk("sat_count",  int'(out_count2), e_cnt2);
        chk("sat_max",    int'(out_max2),   e_max);
        if (!rst) begin
            if (b2b && in_valid && !in_ready) n_bubble++;
            if (out_valid && out_ready) n_hs++;
            if (!m_out && in_valid) begin
                part.push_back(in_trit);
                if (in_last) begin
                    model_result();
                    part.delete();
                    m_out = 1'b1;
                end
            end else if (m_out && out_ready) begin
                m_out = 1'b0;
            end
        end
    end

    // ---------------- downstream ----------------
    int or_mode = 2;   // 0 random, 1 always ready, 2 never ready

    always @(posedge clk) begin
        #1;
        case (or_mode)
            0:       out_ready = (($urandom % 3) == 0);
            1:       out_ready = 1'b1;
            default: out_ready = 1'b0;
        endcase
    end

    // ---------------- upstream ----------------
    logic [1:0] pk[$];
    int         n_expect = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int gap_max, input bit do_last);
        for (int i = 0; i < pk.size(); i++) begin
            bit ok;
            int tries;
            repeat ($urandom_range(0, gap_max)) begin
                in_valid = 1'b0;
                in_trit  = 2'($urandom);
                in_last  = 1'($urandom);
                tick();
            end
            in_valid = 1'b1;
            in_trit  = pk[i];
            in_last  = do_last && (i == pk.size() - 1);
            ok = 1'b0;
            tries = 0;
            while (!ok && tries < 200) begin
                @(negedge clk);
                ok = in_ready;
                tick();
                tries++;
            end
            if (!ok) chk("accept_timeout", 0, 1);
        end
        if (do_last) n_expect++;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_trit = 2'b00;
        in_last = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        or_mode = 0;

        pk = '{2'b00, 2'b01, 2'b10};  send_pkt(0, 1'b1); idle(1);
        pk = '{2'b01, 2'b11, 2'b01};  send_pkt(1, 1'b1); idle(1);
        pk = '{2'b11};                send_pkt(0, 1'b1); idle(1);
        pk = '{2'b10};                send_pkt(0, 1'b1); idle(1);

        // result held with upstream pushing; then released
        or_mode = 1; idle(6);
        or_mode = 2;
        pk = '{2'b10, 2'b00};         send_pkt(0, 1'b1);
        in_valid = 1'b1; in_trit = 2'b10; in_last = 1'b1;
        repeat (5) tick();
        or_mode = 1;
        pk = '{2'b01, 2'b01};         send_pkt(0, 1'b1); idle(2);

        pk = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        send_pkt(1, 1'b1); idle(3);

        // reset mid-packet, then a fresh single-trit packet
        or_mode = 0;
        pk = '{2'b00, 2'b10};         send_pkt(0, 1'b0); idle(1);
        pulse_rst();
        pk = '{2'b01};                send_pkt(0, 1'b1); idle(1);

        // reset while a result is pending
        or_mode = 1; idle(4);
        or_mode = 2;
        pk = '{2'b10, 2'b11};         send_pkt(0, 1'b1); idle(2);
        n_expect--;
        pulse_rst();
        or_mode = 0;

        // long packet saturating the 8-bit counter
        pk.delete();
        for (int i = 0; i < 260; i++) pk.push_back(2'($urandom));
        send_pkt(0, 1'b1); idle(1);

        for (int p = 0; p < 40; p++) begin
            int len = $urandom_range(1, 8);
            bit all_inv = (($urandom % 6) == 0);
            pk.delete();
            for (int i = 0; i < len; i++)
                pk.push_back(all_inv ? 2'b11 : 2'($urandom));
            send_pkt(2, 1'b1);
        end
        in_valid = 1'b0;

        // back-to-back with in_valid held and downstream always ready
        or_mode = 1; idle(6);
        b2b = 1'b1;
        for (int p = 0; p < 10; p++) begin
            int len = $urandom_range(1, 5);
            pk.delete();
            for (int i = 0; i < len; i++) pk.push_back(2'($urandom));
            send_pkt(0, 1'b1);
        end
        in_valid = 1'b0;
        b2b = 1'b0;
        chk("b2b_bubbles", n_bubble, 9);

        idle(8);
        chk("packets", n_hs, n_expect);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/ternary_max_reducer.md
TERNARY_MAX_REDUCER -- requirements
Module: ternary_max_reducer

Interface
REQ-001 Parameter CNT_W, default 8: width of the per-packet trit counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  upstream offers a trit this cycle.
REQ-005 in_trit  input  2  trit: 00 = -, 01 = 0, 10 = +, 11 = invalid.
REQ-006 in_last  input  1  offered trit is the final one of its packet.
REQ-007 in_ready  output  1  block can accept a trit this cycle.
REQ-008 out_valid  output  1  packet result is presented.
REQ-009 out_ready  input  1  downstream accepts the presented result.
REQ-010 out_max  output  2  ternary maximum of the packet's valid trits.
REQ-011 out_min  output  2  ternary minimum of the packet's valid trits.
REQ-012 out_count  output  CNT_W  number of trits accepted in the packet, invalid ones included.
REQ-013 out_err  output  1  packet contained at least one 11 code, or had zero valid trits.

Function
REQ-014 Ordering SHALL be - < 0 < +, with codes 00 < 01 < 10.
REQ-015 FSM SHALL have two states: ACC (accumulating) and OUT (result held).
REQ-016 in_ready SHALL be 1 in ACC and 0 in OUT; it SHALL be a decode of state only.
REQ-017 A trit is accepted on a rising edge with in_valid=1 and in_ready=1; in_trit and in_last are ignored otherwise.
REQ-018 At packet start, the running max SHALL be 00, the running min 10, the count 0, the err flag 0, and the seen-valid flag 0.
REQ-019 An accepted valid trit SHALL update max = max(max, trit) and min = min(min, trit), and SHALL set seen-valid.
REQ-020 An accepted 11 trit SHALL leave max and min unchanged and SHALL set err.
REQ-021 Every accepted trit SHALL increment the count; the count saturates at 2^CW-1 and never wraps.
REQ-022 Accepting a trit with in_last=1 SHALL transition ACC->OUT, with that trit included in the result.
REQ-023 On that same edge, out_max, out_min, out_count, and out_err SHALL be registered; out_valid=1 from the next cycle (latency of 1 cycle from last accept).
REQ-024 If the packet had no valid trit, out_err SHALL be 1, out_max SHALL be 01, and out_min SHALL be 01.
REQ-025 In OUT, out_valid and all out_* SHALL stay stable until out_valid=1 and out_ready=1 on a rising edge.
REQ-026 On that handshake, the FSM SHALL move OUT->ACC, out_valid SHALL go to 0, and accumulators SHALL reinitialise per REQ-018.
REQ-027 out_max, out_min, out_count, and out_err SHALL retain their last values after the handshake until the next packet result.
REQ-028 out_ready SHALL be ignored in ACC.
REQ-029 There is no same-cycle bypass: in_ready=0 during the handshake cycle, giving at minimum a one-cycle bubble between packets.
REQ-030 A single-trit packet (first trit has in_last=1) SHALL be handled identically to longer packets.

Reset
REQ-031 rst=1 SHALL immediately force state ACC and out_valid=0.
REQ-032 rst=1 SHALL immediately force out_max=00, out_min=00, out_count=0, and out_err=0.
REQ-033 rst=1 SHALL immediately reinitialise the accumulators per REQ-018.
REQ-034 While rst=1, no trit SHALL be accepted and in_ready SHALL be 0.
REQ-035 Reset mid-packet or in OUT SHALL discard the partial or pending result with no residual effect on the next packet.

Verification
REQ-036 Packet 00,01,10(last) -> out_valid=1 one cycle after the last accept, out_max=10, out_min=00, out_count=3, out_err=0.
REQ-037 Packet 01,11,01(last) -> out_max=01, out_min=01, out_count=3, out_err=1; packet 11(last) -> out_max=01, out_min=01, out_count=1, out_err=1.
REQ-038 Result held with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs stable, no trit consumed; out_ready=1 -> out_valid=0 and in_ready=1 on the next cycle.
REQ-039 With CNT_W=2, send 6 trits of 10 with last on the 6th -> out_count=3 (saturated), out_max=10, out_min=10.
REQ-040 Assert rst after 2 trits of a packet, release, then send 01(last) -> out_max=01, out_min=01, out_count=1, out_err=0.
REQ-041 Back-to-back packets with in_valid held high and out_ready=1 -> exactly one in_ready=0 bubble per packet, and every trit accounted to the correct packet.
